// File: rtl/osd_regaccess_mux.sv
// osd_regaccess_mux: worm-atomic merge of regaccess responses and bypass traffic into one registered DII output
package osd_dii_pkg;
  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        valid;
  } dii_flit;
endpackage

module osd_regaccess_mux
  import osd_dii_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic    clk,
  input  logic    rst,
  input  dii_flit in_reg,
  output logic    in_reg_ready,
  input  dii_flit in_bypass,
  output logic    in_bypass_ready,
  output dii_flit out,
  input  logic    out_ready
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WORM_REG = 2'd1;
  localparam logic [1:0] WORM_BYP = 2'd2;
  localparam logic GRANT_BYP = 1'b1;
  logic [1:0] state;
  logic       last_grant;
  logic       buf_free;
  logic       sel_byp;
  logic       xfer;
  dii_flit    sel;
  // In IDLE the choice is purely combinational; it only sticks once a flit actually moves.
  always_comb begin
    buf_free = !out.valid || out_ready;
    sel_byp = (state == WORM_BYP) ||
              (state == IDLE && ((in_reg.valid && in_bypass.valid) ? (FAIR && last_grant != GRANT_BYP) : in_bypass.valid));
    sel = sel_byp ? in_bypass : in_reg;
    xfer = !rst && buf_free && sel.valid;
    in_reg_ready = !rst && buf_free && !sel_byp;
    in_bypass_ready = !rst && buf_free && sel_byp;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
      state <= IDLE;
      last_grant <= GRANT_BYP;
    end else begin
      if (xfer) begin
        out.data <= sel.data;
        out.last <= sel.last;
        out.valid <= 1'b1;
        state <= sel.last ? IDLE : (sel_byp ? WORM_BYP : WORM_REG);
      end else if (out_ready) begin
        out.valid <= 1'b0;
      end
      if (xfer && state == IDLE) last_grant <= sel_byp;
    end
  end
endmodule

// File: tb/tb_osd_regaccess_mux.sv
// tb_osd_regaccess_mux: directed table plus hand-written sequences for both arbitration modes
module tb_osd_regaccess_mux;
  import osd_dii_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out_ready = 1'b1;
  bit use0 = 1'b0;
  dii_flit in_reg = '0;
  dii_flit in_bypass = '0;
  dii_flit out1, out0, o;
  logic rr1, br1, rr0, br0, rr, br;
  int checks = 0;
  int errors = 0;
  logic [16:0] oq[$];
  logic [16:0] eq[$];
  always #5 clk = ~clk;
  osd_regaccess_mux #(.FAIR(1'b1)) dut (
    .clk(clk), .rst(rst), .in_reg(in_reg), .in_reg_ready(rr1),
    .in_bypass(in_bypass), .in_bypass_ready(br1), .out(out1), .out_ready(out_ready));
  osd_regaccess_mux #(.FAIR(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_reg(in_reg), .in_reg_ready(rr0),
    .in_bypass(in_bypass), .in_bypass_ready(br0), .out(out0), .out_ready(out_ready));
  assign o = use0 ? out0 : out1;
  assign rr = use0 ? rr0 : rr1;
  assign br = use0 ? br0 : br1;
  typedef struct packed {
    logic    rst;
    dii_flit r;
    dii_flit b;
    logic    ordy;
    logic    chk_rdy;
    logic    err;
    logic    ebr;
    dii_flit eo;
  } vec_t;
  vec_t vec[12];
  function automatic dii_flit mk(input logic v, input logic [16:0] ld);
    return {ld[15:0], ld[16], v};
  endfunction
  function automatic logic [16:0] fl(input logic [15:0] base, input int idx, input int wlen);
    return {logic'(idx % wlen == wlen - 1), base | 16'(idx)};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk_q(input string nm);
    chk({nm, " count"}, 32'(oq.size()), 32'(eq.size()));
    for (int i = 0; i < eq.size() && i < oq.size(); i++) chk(nm, 32'(oq[i]), 32'(eq[i]));
  endtask
  // Drives worm streams on both inputs, honouring readys; logs every flit the sink consumes.
  task automatic stream(input int ncyc, input int reg_n, input int byp_n, input int wlen,
                        input int reg_delay, input int st_lo, input int st_hi);
    int ri = 0;
    int bi = 0;
    bit take_r, take_b;
    bit prev_stall = 1'b0;
    dii_flit held = '0;
    oq.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      rst = 1'b0;
      in_reg = mk(logic'(c >= reg_delay && ri < reg_n * wlen), fl(16'h1000, ri, wlen));
      in_bypass = mk(logic'(bi < byp_n * wlen), fl(16'h2000, bi, wlen));
      out_ready = !(c >= st_lo && c < st_hi);
      #1;
      if (o.valid && out_ready) oq.push_back({o.last, o.data});
      if (o.valid && !out_ready) begin
        chk("stall reg_ready", 32'(rr), 32'd0);
        chk("stall byp_ready", 32'(br), 32'd0);
        if (prev_stall) chk("stall hold", 32'(o), 32'(held));
      end
      prev_stall = o.valid && !out_ready;
      held = o;
      take_r = in_reg.valid && rr;
      take_b = in_bypass.valid && br;
      chk("exclusive grant", 32'(take_r & take_b), 32'd0);
      @(posedge clk);
      if (take_r) ri++;
      if (take_b) bi++;
    end
    @(negedge clk);
    in_reg.valid = 1'b0;
    in_bypass.valid = 1'b0;
    out_ready = 1'b1;
  endtask
  initial begin
    logic [15:0] bd[3];
    vec[0]  = {1'b1, mk(1, {1'b0, 16'h1111}), mk(1, {1'b0, 16'h2222}), 1'b1, 1'b1, 1'b0, 1'b0, mk(0, 17'h0)};
    vec[1]  = {1'b1, mk(1, {1'b0, 16'h1111}), mk(1, {1'b0, 16'h2222}), 1'b1, 1'b1, 1'b0, 1'b0, mk(0, 17'h0)};
    vec[2]  = {1'b0, mk(1, {1'b0, 16'h1111}), mk(1, {1'b0, 16'h2222}), 1'b1, 1'b1, 1'b1, 1'b0, mk(1, {1'b0, 16'h1111})};
    vec[3]  = {1'b0, mk(1, {1'b1, 16'h1112}), mk(1, {1'b0, 16'h2222}), 1'b1, 1'b1, 1'b1, 1'b0, mk(1, {1'b1, 16'h1112})};
    vec[4]  = {1'b0, mk(1, {1'b1, 16'h1113}), mk(1, {1'b0, 16'h2222}), 1'b1, 1'b1, 1'b0, 1'b1, mk(1, {1'b0, 16'h2222})};
    vec[5]  = {1'b0, mk(1, {1'b1, 16'h1113}), mk(1, {1'b1, 16'h2223}), 1'b1, 1'b1, 1'b0, 1'b1, mk(1, {1'b1, 16'h2223})};
    vec[6]  = {1'b0, mk(1, {1'b1, 16'h1113}), mk(0, 17'h0),            1'b1, 1'b1, 1'b1, 1'b0, mk(1, {1'b1, 16'h1113})};
    vec[7]  = {1'b0, mk(0, 17'h0),            mk(0, 17'h0),            1'b1, 1'b0, 1'b0, 1'b0, mk(0, 17'h0)};
    vec[8]  = {1'b0, mk(0, 17'h0),            mk(1, {1'b1, 16'h2001}), 1'b0, 1'b1, 1'b0, 1'b1, mk(1, {1'b1, 16'h2001})};
    vec[9]  = {1'b0, mk(0, 17'h0),            mk(1, {1'b1, 16'h2002}), 1'b0, 1'b1, 1'b0, 1'b0, mk(1, {1'b1, 16'h2001})};
    vec[10] = {1'b0, mk(0, 17'h0),            mk(1, {1'b1, 16'h2002}), 1'b1, 1'b1, 1'b0, 1'b1, mk(1, {1'b1, 16'h2002})};
    vec[11] = {1'b0, mk(0, 17'h0),            mk(0, 17'h0),            1'b1, 1'b0, 1'b0, 1'b0, mk(0, 17'h0)};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rst = vec[i].rst;
      in_reg = vec[i].r;
      in_bypass = vec[i].b;
      out_ready = vec[i].ordy;
      #1;
      if (vec[i].chk_rdy) begin
        chk($sformatf("vec%0d reg_ready", i), 32'(rr), 32'(vec[i].err));
        chk($sformatf("vec%0d byp_ready", i), 32'(br), 32'(vec[i].ebr));
      end
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out.valid", i), 32'(o.valid), 32'(vec[i].eo.valid));
      if (vec[i].eo.valid) chk($sformatf("vec%0d out flit", i), 32'({o.last, o.data}), 32'({vec[i].eo.last, vec[i].eo.data}));
    end
    bd = '{16'h4001, 16'h0002, 16'h0003};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_reg.valid = 1'b0;
      in_bypass = mk(1, {logic'(k == 2), bd[k]});
      out_ready = 1'b1;
      #1;
      chk($sformatf("bypass stream %0d reg_ready", k), 32'(rr), 32'd0);
      chk($sformatf("bypass stream %0d byp_ready", k), 32'(br), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("bypass stream %0d out", k), 32'(o), 32'(mk(1, {logic'(k == 2), bd[k]})));
    end
    @(negedge clk);
    in_bypass.valid = 1'b0;
    stream(13, 3, 3, 2, 0, 100, 100);
    eq.delete();
    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 2; j++) eq.push_back(fl(16'h1000, w * 2 + j, 2));
    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 2; j++) eq.insert(w * 4 + 2 + j, fl(16'h2000, w * 2 + j, 2));
    chk_q("fair contention");
    stream(11, 1, 0, 4, 0, 2, 7);
    eq.delete();
    for (int j = 0; j < 4; j++) eq.push_back(fl(16'h1000, j, 4));
    chk_q("backpressure");
    @(negedge clk);
    rst = 1'b0;
    in_reg = mk(1, {1'b0, 16'h3001});
    in_bypass.valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset first flit", 32'(o), 32'(mk(1, {1'b0, 16'h3001})));
    @(negedge clk);
    rst = 1'b1;
    in_reg = mk(1, {1'b0, 16'h3002});
    #1;
    chk("midreset reg_ready", 32'(rr), 32'd0);
    chk("midreset byp_ready", 32'(br), 32'd0);
    @(posedge clk);
    #1;
    chk("midreset out.valid", 32'(o.valid), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rst = 1'b0;
      in_reg.valid = 1'b0;
      in_bypass = mk(1, {logic'(k == 1), 16'h5001 + 16'(k)});
      #1;
      chk($sformatf("post reset byp_ready %0d", k), 32'(br), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("post reset out %0d", k), 32'(o), 32'(mk(1, {logic'(k == 1), 16'h5001 + 16'(k)})));
    end
    @(negedge clk);
    rst = 1'b1;
    in_reg.valid = 1'b0;
    in_bypass.valid = 1'b0;
    use0 = 1'b1;
    stream(16, 3, 2, 3, 1, 100, 100);
    eq.delete();
    for (int j = 0; j < 3; j++) eq.push_back(fl(16'h2000, j, 3));
    for (int j = 0; j < 9; j++) eq.push_back(fl(16'h1000, j, 3));
    for (int j = 3; j < 6; j++) eq.push_back(fl(16'h2000, j, 3));
    chk_q("fixed priority");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
